// File: rtl/ram_512_loader.sv
// ram_512_loader
// ----------------------------------------------------------------------------
// Bulk-write front end placed directly in front of a 512 x 16 RAM. While idle
// it passes the CPU write port through unchanged. On `start` it streams a block
// of words from a valid/ready source into consecutive (wrapping) addresses. On
// `clear` it writes FILL_VALUE to every address, when that feature is built.
//
// Build option:
//   RAM512_LOADER_CLEAR_EN  when defined, builds the CLEAR sequence and makes
//                           `clear` functional. When undefined, `clear` is
//                           ignored. The port list is the same in both builds.
//
// Parameters:
//   FILL_VALUE     word written by the clear sequence
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset
//   start          one-cycle load request (IDLE only)
//   start_address  first RAM address of the load, sampled with start
//   count          words to load (0..512, larger values saturate to 512)
//   clear          one-cycle clear request (IDLE only, wins over start)
//   s_data/s_valid stream input; s_ready is high while loading
//   cpu_in/cpu_address/cpu_load  CPU write port, passed through in IDLE
//   ram_in/ram_address/ram_load  drive the RAM write port
//   busy           high in LOAD or CLEAR
//   done           one-cycle completion pulse
//   words_written  words written by the current or last operation
// ----------------------------------------------------------------------------
module ram_512_loader #(
  parameter logic [15:0] FILL_VALUE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  start_address,
  input  logic [9:0]  count,
  input  logic        clear,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] cpu_in,
  input  logic [8:0]  cpu_address,
  input  logic        cpu_load,
  output logic [15:0] ram_in,
  output logic [8:0]  ram_address,
  output logic        ram_load,
  output logic        busy,
  output logic        done,
  output logic [9:0]  words_written
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [8:0] ptr_q, ptr_d;
  logic [9:0] remaining_q, remaining_d;
  logic [9:0] words_q, words_d;
  logic [9:0] count_sat;

  // Requests above the array size are clamped so a load never laps itself.
  assign count_sat = (count > 10'd512) ? 10'd512 : count;

`ifndef RAM512_LOADER_CLEAR_EN
  // Clear feature not built: the input and fill word are intentionally unused.
  logic unused_clear;
  assign unused_clear = ^{clear, FILL_VALUE};
`endif

  // Next-state logic.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    words_d     = words_q;
    case (state_q)
      ST_IDLE: begin
`ifdef RAM512_LOADER_CLEAR_EN
        if (clear) begin
          state_d = ST_CLEAR;
          ptr_d   = 9'd0;
          words_d = 10'd0;
        end else
`endif
        if (start) begin
          ptr_d       = start_address;
          remaining_d = count_sat;
          words_d     = 10'd0;
          state_d     = (count_sat == 10'd0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        // s_ready is 1 throughout LOAD, so s_valid alone marks a transfer.
        if (s_valid) begin
          ptr_d       = ptr_q + 9'd1;     // wraps 511 -> 0 by width
          words_d     = words_q + 10'd1;
          remaining_d = remaining_q - 10'd1;
          if (remaining_q == 10'd1) state_d = ST_DONE;
        end
      end
`ifdef RAM512_LOADER_CLEAR_EN
      ST_CLEAR: begin
        ptr_d   = ptr_q + 9'd1;
        words_d = words_q + 10'd1;
        if (ptr_q == 9'd511) state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM port mux. The write lands on the same edge the transfer is accepted.
  always_comb begin
    ram_in      = cpu_in;
    ram_address = cpu_address;
    ram_load    = cpu_load;
    s_ready     = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_LOAD: begin
        ram_in      = s_data;
        ram_address = ptr_q;
        ram_load    = s_valid;
        s_ready     = 1'b1;
      end
`ifdef RAM512_LOADER_CLEAR_EN
      ST_CLEAR: begin
        ram_in      = FILL_VALUE;
        ram_address = ptr_q;
        ram_load    = 1'b1;
      end
`endif
      default: begin
        // DONE (or an unbuilt state): CPU writes are dropped, not queued.
        ram_in      = 16'h0000;
        ram_address = ptr_q;
        ram_load    = 1'b0;
      end
    endcase
    // Reset must never disturb RAM contents, and no handshake completes.
    if (reset) begin
      ram_load = 1'b0;
      s_ready  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 9'd0;
      remaining_q <= 10'd0;
      words_q     <= 10'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      words_q     <= words_d;
    end
  end

  assign busy          = (state_q == ST_LOAD) || (state_q == ST_CLEAR);
  assign done          = (state_q == ST_DONE);
  assign words_written = words_q;

endmodule

// File: tb/tb_ram_512_loader.sv
// tb_ram_512_loader
// Directed + randomized bench for ram_512_loader. A behavioural RAM sits on
// the ram_* port; an expected-contents array is updated from the block-level
// rules (address = start + i mod 512, CPU writes only in IDLE, clear fills all).
module tb_ram_512_loader;

  localparam logic [15:0] FILL = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  start_address;
  logic [9:0]  count;
  logic        clear;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] cpu_in;
  logic [8:0]  cpu_address;
  logic        cpu_load;
  logic [15:0] ram_in;
  logic [8:0]  ram_address;
  logic        ram_load;
  logic        busy;
  logic        done;
  logic [9:0]  words_written;

  always #5 clk = ~clk;

  ram_512_loader #(.FILL_VALUE(FILL)) dut (
    .clk(clk), .reset(reset), .start(start), .start_address(start_address),
    .count(count), .clear(clear), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .cpu_in(cpu_in), .cpu_address(cpu_address),
    .cpu_load(cpu_load), .ram_in(ram_in), .ram_address(ram_address),
    .ram_load(ram_load), .busy(busy), .done(done),
    .words_written(words_written)
  );

  logic [15:0] ram     [512];
  logic [15:0] exp_mem [512];
  always @(posedge clk) if (ram_load) ram[ram_address] <= ram_in;

  int checks = 0;
  int errors = 0;
  logic [15:0] load_data [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 512; i++) if (ram[i] !== exp_mem[i]) bad++;
    check(tag, bad, 0);
  endtask

  task automatic fill_random(input int n);
    load_data.delete();
    for (int i = 0; i < n; i++) load_data.push_back(16'($urandom));
  endtask

  // gap_mode: 0 = s_valid always high, 1 = low on alternate cycles, 2 = random
  task automatic run_load(input logic [8:0] sa, input logic [9:0] cnt,
                          input int gap_mode, input bit contend);
    int n, idx, cyc;
    logic v;
    n = (cnt > 10'd512) ? 512 : int'(cnt);
    start = 1'b1; start_address = sa; count = cnt; s_valid = 1'b0;
    tick();
    start = 1'b0; start_address = 9'($urandom); count = 10'($urandom);
    idx = 0; cyc = 0;
    while (idx < n && cyc < 4 * n + 16) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid = v;
      s_data  = load_data[idx];
      if (contend) begin
        cpu_load = 1'b1; cpu_address = 9'd5; cpu_in = 16'($urandom);
      end
      #1;
      check("load_s_ready", s_ready, 1);
      check("load_busy", busy, 1);
      check("load_done_low", done, 0);
      check("load_ram_load", ram_load, v);
      tick();
      if (v) begin
        exp_mem[(int'(sa) + idx) % 512] = load_data[idx];
        idx++;
      end
      cyc++;
    end
    check("load_transfers", idx, n);
    s_valid = 1'b0;
    #1;
    check("done_pulse", done, 1);
    check("done_busy_low", busy, 0);
    check("done_no_write", ram_load, 0);
    check("done_s_ready_low", s_ready, 0);
    tick();
    cpu_load = 1'b0;
    check("done_single", done, 0);
    check("words_written", words_written, n);
    tick();
    check("words_written_hold", words_written, n);
    check_mem("mem_after_load");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    logic [15:0] w;
    for (int i = 0; i < 512; i++) begin
      w = 16'($urandom) | 16'h0001;   // nonzero so a clear is visible
      ram[i] = w;
      exp_mem[i] = w;
    end
    reset = 1'b1; start = 1'b0; clear = 1'b0; start_address = 9'd0; count = 10'd0;
    s_data = 16'h0; s_valid = 1'b0;
    cpu_in = 16'h1234; cpu_address = 9'd7; cpu_load = 1'b1;

    // Reset: outputs idle, RAM write suppressed even with cpu_load high.
    tick(); tick();
    check("reset_ram_load", ram_load, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_s_ready", s_ready, 0);
    check("reset_words", words_written, 0);
    cpu_load = 1'b0; reset = 1'b0;
    #1;
    check("idle_pass_addr", ram_address, 9'd7);
    check("idle_pass_data", ram_in, 16'h1234);
    check("reset_no_write", ram[7], exp_mem[7]);

    // Passthrough write in IDLE.
    cpu_address = 9'd300; cpu_in = 16'hBEEF; cpu_load = 1'b1;
    #1;
    check("pass_ram_load", ram_load, 1);
    tick();
    cpu_load = 1'b0;
    exp_mem[300] = 16'hBEEF;
    check("pass_ram300", ram[300], 16'hBEEF);
    check("pass_busy", busy, 0);
    check("pass_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      cpu_address = 9'($urandom); cpu_in = 16'($urandom); cpu_load = 1'b1;
      tick();
      exp_mem[cpu_address] = cpu_in;
      cpu_load = 1'b0;
    end
    check_mem("mem_after_cpu");

    // Load with gaps: 1,2,3,4 into 10..13.
    load_data = '{16'd1, 16'd2, 16'd3, 16'd4};
    run_load(9'd10, 10'd4, 1, 1'b0);
    for (int i = 0; i < 4; i++)
      check($sformatf("gap_ram%0d", 10 + i), ram[10 + i], 16'(i + 1));
    check("gap_ram14_untouched", ram[14], exp_mem[14]);

    // Wrap across 511 -> 0.
    load_data = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    run_load(9'd510, 10'd3, 0, 1'b0);
    check("wrap_ram510", ram[510], 16'hAAAA);
    check("wrap_ram511", ram[511], 16'hBBBB);
    check("wrap_ram0", ram[0], 16'hCCCC);

    // Count 0: DONE on the next cycle, nothing written.
    load_data.delete();
    run_load(9'd123, 10'd0, 0, 1'b0);

    // Contention: CPU writes to address 5 during a load are dropped.
    fill_random(6);
    run_load(9'd100, 10'd6, 2, 1'b1);
    check("contend_ram5", ram[5], exp_mem[5]);

    // Random loads with random gaps.
    for (int k = 0; k < 3; k++) begin
      int n;
      n = $urandom_range(1, 40);
      fill_random(n);
      run_load(9'($urandom), 10'(n), 2, 1'b0);
    end

    // Oversized count saturates to 512.
    fill_random(512);
    run_load(9'($urandom), 10'd1000, 0, 1'b0);

    // Reset mid-load after 3 transfers.
    fill_random(8);
    start = 1'b1; start_address = 9'd200; count = 10'd8;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = load_data[i];
      tick();
      exp_mem[200 + i] = load_data[i];
    end
    s_valid = 1'b1; s_data = load_data[3]; reset = 1'b1;
    #1;
    check("rst_mid_ram_load", ram_load, 0);
    tick();
    reset = 1'b0; s_valid = 1'b0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_words", words_written, 0);
    tick();
    check("rst_mid_no_done_later", done, 0);
    check_mem("mem_after_rst_mid");

`ifdef RAM512_LOADER_CLEAR_EN
    // start and clear together: clear wins and fills the whole array.
    start = 1'b1; clear = 1'b1; start_address = 9'd0; count = 10'd5;
    tick();
    start = 1'b0; clear = 1'b0;
    check("clear_busy", busy, 1);
    check("clear_ram_load", ram_load, 1);
    check("clear_s_ready", s_ready, 0);
    check("clear_first_addr", ram_address, 0);
    check("clear_fill_data", ram_in, FILL);
    cyc = 0;
    while (done !== 1'b1 && cyc < 600) begin
      tick();
      cyc++;
    end
    check("clear_cycles", cyc, 512);
    check("clear_words", words_written, 512);
    tick();
    check("clear_done_single", done, 0);
    for (int i = 0; i < 512; i++) exp_mem[i] = FILL;
    check_mem("mem_after_clear");
`else
    // Clear not built: request ignored, memory unchanged.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_off_busy", busy, 0);
    check("clear_off_done", done, 0);
    cyc = 0;
    while (cyc < 4) begin
      tick();
      check("clear_off_stay_idle", busy, 0);
      cyc++;
    end
    check_mem("mem_clear_off");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_512_loader.md
# ram_512_loader

Bulk-write front end that sits directly upstream of the 512-word RAM and drives its `in`/`address`/`load` inputs. When idle it passes the CPU-side write port straight through. On command it takes over the RAM port to stream a block of words from a valid/ready source into consecutive addresses, or to clear the whole array. It is used for program/data preload and for memory scrub after boot.

## Interface
- `FILL_VALUE`, default 16'h0000: word written by the clear sequence.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; begins a load when in IDLE.
- `start_address`  in  9  first RAM address of the load; sampled with `start`.
- `count`  in  10  number of words to load; sampled with `start`; valid range 0..512.
- `clear`  in  1  one-cycle request; begins a clear when in IDLE (only with `RAM512_LOADER_CLEAR_EN`).
- `s_data`  in  16  stream word.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  loader accepts `s_data` this cycle.
- `cpu_in`  in  16  CPU write data.
- `cpu_address`  in  9  CPU address.
- `cpu_load`  in  1  CPU write enable.
- `ram_in`  out  16  to RAM `in`.
- `ram_address`  out  9  to RAM `address`.
- `ram_load`  out  1  to RAM `load`.
- `busy`  out  1  high in LOAD or CLEAR.
- `done`  out  1  one-cycle pulse on completion of a load or clear.
- `words_written`  out  10  words written by the current or last operation.

## Operation
- States: IDLE, LOAD, CLEAR, DONE.
- IDLE: `ram_in`/`ram_address`/`ram_load` = `cpu_in`/`cpu_address`/`cpu_load`, combinationally. `s_ready`=0.
- IDLE -> LOAD on `start`. `ptr` <= `start_address`, `remaining` <= `count`, and `words_written` <= 0. If `count` = 0, go to DONE instead with no writes. A `count` > 512 saturates to 512.
- LOAD: `s_ready`=1. `ram_address`=`ptr`, `ram_in`=`s_data`, `ram_load` = `s_valid`. Each accepted word increments `ptr` and `words_written` and decrements `remaining`. `ptr` wraps 511 -> 0. The transfer that makes `remaining` reach 0 moves to DONE. A `s_valid`=0 cycle writes nothing and holds state.
- IDLE -> CLEAR on `clear`. `ptr` <= 0. Writes `FILL_VALUE` to one address per cycle (`ram_load`=1, `s_ready`=0), 0 through 511. After writing 511 it moves to DONE. `words_written` ends at 512.
- DONE: `done`=1 for exactly one cycle, `ram_load`=0, CPU port not passed through. Next state is IDLE.
- If `start` and `clear` are both high in IDLE, `clear` wins.
- `start`/`clear` while not in IDLE are ignored.
- `cpu_load` while not in IDLE is dropped: no write occurs and it is not queued.
- `words_written` holds its final value in IDLE until the next accepted `start`/`clear`.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `s_ready`=0, `words_written`=0, internal `ptr`=0, `remaining`=0. The `ram_*` outputs follow the CPU port.
- `ram_load` is forced to 0 in any cycle where `reset`=1. RAM contents are not touched by reset.
- Reset mid-operation: the sequence aborts at the next edge, with no `done` pulse. Words already written stay written.
- A load of N words with `s_valid` held high takes the `start` cycle, N LOAD cycles, and 1 DONE cycle. `busy` is high for exactly N cycles.
- A clear takes 512 CLEAR cycles followed by 1 DONE cycle.
- Handshake: a transfer occurs on a rising edge with `s_valid`&&`s_ready`. The source must hold `s_data` while `s_valid`=1 and `s_ready`=0.
- The RAM write lands on the same edge the transfer is accepted. There is no extra pipeline stage.

## Configuration
- `RAM512_LOADER_CLEAR_EN` defined: the CLEAR state and `clear` input are functional, and `FILL_VALUE` is used.
- Not defined: the CLEAR state is not built and `clear` is ignored. `start` is the only way to leave IDLE. The port list is unchanged.

## Test plan
- Passthrough: in IDLE, `cpu_address`=9'd300, `cpu_in`=16'hBEEF, `cpu_load`=1 -> RAM[300] reads 16'hBEEF, and `busy`/`done` stay 0.
- Load with gaps: `start`, `start_address`=10, `count`=4, data 1,2,3,4 with `s_valid` low on alternate cycles -> RAM[10..13]=1,2,3,4. `done` pulses once, `words_written`=4, and RAM[14] is unchanged.
- Wrap and count 0: `start_address`=510, `count`=3, data A,B,C -> RAM[510]=A, RAM[511]=B, RAM[0]=C. A separate `start` with `count`=0 -> `done` on the next cycle, no `ram_load`, `words_written`=0.
- Clear (macro on): preload nonzero data, pulse `clear` -> after 513 cycles `done`=1 and all 512 words equal 16'h0000. With the macro off, `clear` leaves `busy`=0 and memory unchanged.
- Contention: `cpu_load`=1 to address 5 during a LOAD -> RAM[5] is unmodified by the CPU. Assert `start` and `clear` together in IDLE -> the clear runs.
- Reset mid-load: `count`=8, assert `reset` after 3 transfers -> `busy`=0 next cycle, no `done`, `words_written`=0. Only the first 3 words are written.
